// File: rtl/fact_sequencer.sv
// Multi-cycle factorial sequencer: iterates acc *= k for k = 2..n using a
// shift-add multiplier that consumes one multiplier bit per cycle.
module fact_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   n, n_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [WIDTH:0]     k, k_nx;
  logic [2*WIDTH-1:0] mcand, mcand_nx;
  logic [WIDTH-1:0]   mplier, mplier_nx;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [CW-1:0]      bitcnt, bitcnt_nx;
  logic               ovf_sticky, ovf_sticky_nx;
  logic [WIDTH-1:0]   result_nx;
  logic               overflow_nx;

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n          <= '0;
      acc        <= '0;
      k          <= '0;
      mcand      <= '0;
      mplier     <= '0;
      prod       <= '0;
      bitcnt     <= '0;
      ovf_sticky <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      n          <= n_nx;
      acc        <= acc_nx;
      k          <= k_nx;
      mcand      <= mcand_nx;
      mplier     <= mplier_nx;
      prod       <= prod_nx;
      bitcnt     <= bitcnt_nx;
      ovf_sticky <= ovf_sticky_nx;
      result     <= result_nx;
      overflow   <= overflow_nx;
    end
  end

  // Next-state and datapath updates; abort overrides the case decode.
  always_comb begin
    state_nx      = state;
    n_nx          = n;
    acc_nx        = acc;
    k_nx          = k;
    mcand_nx      = mcand;
    mplier_nx     = mplier;
    prod_nx       = prod;
    bitcnt_nx     = bitcnt;
    ovf_sticky_nx = ovf_sticky;
    result_nx     = result;
    overflow_nx   = overflow;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_nx          = operand;
          acc_nx        = WIDTH'(1);
          k_nx          = (WIDTH + 1)'(2);
          ovf_sticky_nx = 1'b0;
          state_nx      = S_CHECK;
        end
      end

      S_CHECK: begin
        // k is one bit wider than n, so k > n terminates even for n = 2^WIDTH-1.
        if (ovf_sticky || (k > {1'b0, n})) begin
          result_nx   = acc;
          overflow_nx = ovf_sticky;
          state_nx    = S_DONE;
        end else begin
          mcand_nx  = {{WIDTH{1'b0}}, acc};
          mplier_nx = k[WIDTH-1:0];
          prod_nx   = '0;
          bitcnt_nx = '0;
          state_nx  = S_MUL;
        end
      end

      S_MUL: begin
        // Fixed WIDTH cycles regardless of mplier contents.
        if (mplier[0]) begin
          prod_nx = prod + mcand;
        end
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        bitcnt_nx = bitcnt + CW'(1);
        if (bitcnt == CW'(WIDTH - 1)) begin
          state_nx = S_NEXT;
        end
      end

      S_NEXT: begin
        acc_nx = prod[WIDTH-1:0];
        if (|prod[2*WIDTH-1:WIDTH]) begin
          ovf_sticky_nx = 1'b1;
        end
        k_nx     = k + (WIDTH + 1)'(1);
        state_nx = S_CHECK;
      end

      S_DONE: begin
        if (start) begin
          n_nx          = operand;
          acc_nx        = WIDTH'(1);
          k_nx          = (WIDTH + 1)'(2);
          ovf_sticky_nx = 1'b0;
          state_nx      = S_CHECK;
        end else begin
          state_nx = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort also suppresses a CHECK->DONE result update in the same cycle.
    if (abort && (state != S_IDLE)) begin
      state_nx    = S_IDLE;
      result_nx   = result;
      overflow_nx = overflow;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_fact_sequencer.sv
// Self-checking bench for fact_sequencer (WIDTH=16): scoreboard of expected
// result/overflow/latency computed by a behavioural factorial model.
module tb_fact_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] operand;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;

  fact_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .operand  (operand),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned e0       = 0;

  // Behavioural model: plain repeated multiply, truncated, stop after first overflow.
  function automatic exp_t model(input logic [W-1:0] n);
    exp_t              e;
    logic [W-1:0]      a;
    longint unsigned   p;
    int unsigned       nn;
    int unsigned       iters;
    logic              ov;
    a     = W'(1);
    ov    = 1'b0;
    iters = 0;
    nn    = int'(n);
    for (int unsigned kk = 2; kk <= nn && !ov; kk++) begin
      p     = longint'(a) * longint'(kk);
      a     = p[W-1:0];
      ov    = ((p >> W) != 0);
      iters = iters + 1;
    end
    e.res = a;
    e.ovf = ov;
    e.lat = 2 + iters * (W + 2);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; the edge just passed is E0.
  task automatic launch(input logic [W-1:0] nval);
    start   = 1'b1;
    operand = nval;
    e0      = cyc;
    sb.push_back(model(nval));
    step();
    start   = 1'b0;
    operand = W'($urandom);
  endtask

  task automatic wait_done(output bit seen, output int unsigned lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc - e0;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    bit          seen;
    int unsigned lat;
    exp_t        e;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d ovf=%b, want 0 0 0 0", busy, done, result, overflow);
    end
    // Establish a nonzero result so clearing is observable.
    launch(W'(6));
    wait_done(seen, lat);
    e = sb.pop_front();
    checks++;
    if (!seen || result !== e.res) begin
      failures++;
      $display("FAIL reset_prerun: seen=%0d result=%0d, want %0d", seen, result, e.res);
    end
    step();
    launch(W'(6));
    void'(sb.pop_back());
    repeat (4) step();
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_mul: busy=%b done=%b result=%0d ovf=%b, want 0 0 0 0", busy, done, result, overflow);
    end
    step();
    rst = 1'b0;
    launch(W'(3));
    wait_done(seen, lat);
    e = sb.pop_front();
    checks++;
    if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat) begin
      failures++;
      $display("FAIL reset_then_n3: seen=%0d result=%0d ovf=%b lat=%0d, want %0d %b %0d", seen, result, overflow, lat, e.res, e.ovf, e.lat);
    end
    step();
  endtask

  task automatic test_trivial();
    bit          seen;
    int unsigned lat;
    exp_t        e;
    for (int t = 0; t < 2; t++) begin
      launch(W'(t));
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL trivial_e1_n%0d: busy=%b done=%b, want 1 0", t, busy, done);
      end
      wait_done(seen, lat);
      e = sb.pop_front();
      checks++;
      if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat || busy !== 1'b1) begin
        failures++;
        $display("FAIL trivial_n%0d: seen=%0d result=%0d ovf=%b lat=%0d busy=%b, want 1 0 %0d 1", t, seen, result, overflow, lat, busy, e.lat);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL trivial_end_n%0d: busy=%b done=%b, want 0 0", t, busy, done);
      end
    end
  endtask

  task automatic test_normal();
    bit           seen;
    int unsigned  lat;
    exp_t         e;
    logic [W-1:0] ns[2];
    ns[0] = W'(5);
    ns[1] = W'(8);
    for (int t = 0; t < 2; t++) begin
      launch(ns[t]);
      wait_done(seen, lat);
      e = sb.pop_front();
      checks++;
      if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat) begin
        failures++;
        $display("FAIL normal_n%0d: seen=%0d result=%0d ovf=%b lat=%0d, want %0d %b %0d", ns[t], seen, result, overflow, lat, e.res, e.ovf, e.lat);
      end
      step();
    end
  endtask

  task automatic test_overflow();
    bit           seen;
    int unsigned  lat;
    exp_t         e;
    logic [W-1:0] ns[3];
    ns[0] = W'(9);
    ns[1] = W'(10);
    ns[2] = W'(65535);
    for (int t = 0; t < 3; t++) begin
      launch(ns[t]);
      wait_done(seen, lat);
      e = sb.pop_front();
      checks++;
      if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat) begin
        failures++;
        $display("FAIL overflow_n%0d: seen=%0d result=%0d ovf=%b lat=%0d, want %0d %b %0d", ns[t], seen, result, overflow, lat, e.res, e.ovf, e.lat);
      end
      step();
    end
  endtask

  task automatic test_protocol();
    bit           seen;
    int unsigned  lat;
    exp_t         e;
    logic [W-1:0] held;
    bit           stray_done;
    launch(W'(5));
    for (int i = 0; i < 50; i++) begin
      start   = 1'($urandom_range(0, 1));
      operand = W'($urandom);
      step();
    end
    start = 1'b0;
    wait_done(seen, lat);
    e = sb.pop_front();
    checks++;
    if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat) begin
      failures++;
      $display("FAIL protocol_noise: seen=%0d result=%0d ovf=%b lat=%0d, want %0d %b %0d", seen, result, overflow, lat, e.res, e.ovf, e.lat);
    end
    held = e.res;
    step();
    launch(W'(7));
    void'(sb.pop_back());
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== held || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_mul: busy=%b done=%b result=%0d ovf=%b, want 0 0 %0d 0", busy, done, result, overflow, held);
    end
    stray_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (done || busy) stray_done = 1'b1;
      step();
    end
    checks++;
    if (stray_done || result !== held) begin
      failures++;
      $display("FAIL abort_quiet: activity=%0d result=%0d, want 0 %0d", stray_done, result, held);
    end
  endtask

  task automatic test_back_to_back();
    bit          seen;
    bit          busy_ok;
    int unsigned lat;
    exp_t        e;
    launch(W'(3));
    wait_done(seen, lat);
    e = sb.pop_front();
    checks++;
    if (!seen || result !== e.res || lat !== e.lat) begin
      failures++;
      $display("FAIL b2b_first: seen=%0d result=%0d lat=%0d, want %0d %0d", seen, result, lat, e.res, e.lat);
    end
    // Second run's latency is counted from the first run's done edge.
    start   = 1'b1;
    operand = W'(4);
    e0      = cyc;
    sb.push_back(model(W'(4)));
    step();
    start   = 1'b0;
    operand = W'($urandom);
    busy_ok = 1'b1;
    seen    = 1'b0;
    lat     = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - e0;
      end else begin
        step();
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen || result !== e.res || overflow !== e.ovf || lat !== e.lat) begin
      failures++;
      $display("FAIL b2b_second: seen=%0d result=%0d ovf=%b lat=%0d, want %0d %b %0d", seen, result, overflow, lat, e.res, e.ovf, e.lat);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL b2b_busy: busy dropped=1, want 0");
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    operand = '0;
    #1;
    test_reset();
    test_trivial();
    test_normal();
    test_overflow();
    test_protocol();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
